byte_packer: RTL and testbench
==============================

# byte_packer

Assembles a serial stream of bytes into 32-bit words and presents each completed word to the splitter stage, which consumes it as its 32-bit input. Bytes arrive one per cycle under a valid/ready handshake, and completed words leave under a second valid/ready handshake. A last-byte marker closes a partial word early, padding the unused low-order bytes. The first byte received lands in bits [31:24], so it appears on the splitter's first byte output.

## Interface
- PAD, 8'h00, fill value for byte lanes not supplied when a word is closed early by in_last.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- in_valid  input  1  in_byte and in_last are valid this cycle.
- in_ready  output  1  the block accepts a byte this cycle.
- in_byte  input  8  data byte.
- in_last  input  1  this byte closes the current word, even if fewer than 4 bytes have been collected.
- out_valid  output  1  out_word and out_len hold a completed word.
- out_ready  input  1  downstream takes the word this cycle.
- out_word  output  32  assembled word; the first byte is in [31:24] and the fourth byte is in [7:0].
- out_len  output  3  number of real bytes in out_word (1..4).

## Operation
- Handshake events:
  - Input fire: in_valid && in_ready.
  - Output fire: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready only and never depends on in_valid.
- Internal state:
  - acc[23:0] holds the pending bytes.
  - cnt[1:0] is the number of bytes already collected for the current word (0..3).
- Input fire with cnt < 3 and in_last = 0:
  - in_byte is stored into lane cnt (lane 0 = [31:24]).
  - cnt increments.
- Input fire with cnt = 3, or with in_last = 1 (a completing byte):
  - The word is formed from the acc lanes 0..cnt-1, then in_byte in lane cnt, then PAD in the remaining lanes.
  - out_word is loaded with that word.
  - out_len is loaded with cnt+1.
  - out_valid is set to 1.
  - cnt returns to 0.
- Output fire with no completing byte in the same cycle: out_valid is cleared. out_word and out_len keep their values.
- Output fire and completing byte in the same cycle: the new word is loaded and out_valid stays 1. There is no bubble.
- Two-state view:
  - EMPTY (out_valid = 0): always accepting bytes.
  - FULL (out_valid = 1): accepting bytes only while out_ready = 1.
  - Transitions are as described above.
- While stalled (out_valid = 1, out_ready = 0), acc, cnt, out_word and out_len are all frozen.
- in_last on the 4th byte behaves the same as a normal full word (out_len = 4).
- in_byte and in_last are ignored whenever the input does not fire.

## Timing
- Reset values: out_valid 0, out_word 32'h0, out_len 0, cnt 0, acc 0, so in_ready = 1 out of reset.
- Reset has priority over every handshake in the same cycle.
- Reset mid-word discards the partial bytes and any word held in the output register.
- Latency: out_valid rises on the edge that accepts the completing byte, so the word is visible in the following cycle.
- Throughput:
  - One byte per cycle sustained.
  - One word every 4 cycles when out_ready is held at 1.
- Outputs are registered. The only combinational path is in_ready ← out_ready.

## Structure
- Single flat module. No sub-module: the lane-insert logic is a 4-way decode of cnt.
- Shared constants header: byte-lane width (8), lanes per word (4), and the lane-to-bit mapping (lane 0 = [31:24]). The splitter stage uses the same mapping.
- Local only: the width of cnt.

## Test plan
- Accept 8'h12, 8'h34, 8'h56, 8'h78 with out_ready = 1 → one cycle after the 4th byte: out_word = 32'h12345678, out_len = 4; the splitter then shows 8'h12 on its first byte output.
- Accept 8'hAB, then 8'hCD with in_last = 1, PAD = 8'h00 → out_word = 32'hABCD0000, out_len = 2. Repeat with PAD = 8'hFF → out_word = 32'hABCDFFFF.
- Complete a word with out_ready = 0 → out_valid stays 1 and in_ready = 0; a 5th byte held on in_valid is not accepted. Raise out_ready → the word is taken, and the held byte is accepted in that same cycle.
- Stream 8 bytes 8'h01..8'h08 continuously with out_ready = 1 → words 32'h01020304 then 32'h05060708; out_valid is never low between them and in_ready stays 1.
- Accept 8'h11 and 8'h22, assert reset for one cycle, then send 8'hA1..8'hA4 → out_word = 32'hA1A2A3A4, out_len = 4; no trace of 8'h11 or 8'h22.
- Single byte 8'h5A with in_last = 1 on cnt = 0 → out_word = 32'h5A000000, out_len = 1.

Source files
------------

// File: rtl/byte_packer_pkg.sv
// rtl/byte_packer_pkg.sv - shared byte-lane constants and lane-to-bit mapping
package byte_packer_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = LANE_W * LANES;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Lane 0 is the most significant byte; the splitter stage relies on this.
    function automatic int lane_msb(input int lane);
        return WORD_W - 1 - lane * LANE_W;
    endfunction

    function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                   input int lane,
                                                   input logic [LANE_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = w;
        r[lane_msb(lane) -: LANE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/byte_packer_if.sv
// rtl/byte_packer_if.sv - byte input and word output handshakes of the packer
interface byte_packer_if;
    import byte_packer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [LANE_W-1:0] in_byte;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [2:0]        out_len;

    modport master (
        output in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_len
    );

    modport slave (
        input  in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out_word, out_len
    );

endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a byte stream into 32-bit words, first byte in [31:24]
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter logic [LANE_W-1:0] PAD = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    byte_packer_if.slave  bus
);

    localparam int CNT_W = 2;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [WORD_W-LANE_W-1:0] acc, acc_next;
    logic [WORD_W-1:0]      word_q, word_next;
    logic [2:0]             len_q, len_next;

    logic                   in_fire, out_fire, completing;
    logic [WORD_W-1:0]      formed, acc_ins;

    assign bus.in_ready  = (state == EMPTY) || bus.out_ready;
    assign bus.out_valid = (state == FULL);
    assign bus.out_word  = word_q;
    assign bus.out_len   = len_q;

    assign in_fire    = bus.in_valid && bus.in_ready;
    assign out_fire   = bus.out_valid && bus.out_ready;
    assign completing = in_fire && ((cnt == 2'd3) || bus.in_last);

    // Lanes below cnt come from acc, lane cnt takes the new byte, the rest are padded.
    always_comb begin
        formed  = {acc, PAD};
        acc_ins = {acc, PAD};
        for (int k = 0; k < LANES; k++) begin
            if (k == int'(cnt)) begin
                formed  = put_lane(formed, k, bus.in_byte);
                acc_ins = put_lane(acc_ins, k, bus.in_byte);
            end else if (k > int'(cnt)) begin
                formed  = put_lane(formed, k, PAD);
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        word_next  = word_q;
        len_next   = len_q;
        if (completing) begin
            word_next  = formed;
            len_next   = 3'(cnt) + 3'd1;
            cnt_next   = '0;
            state_next = FULL;
        end else begin
            if (in_fire) begin
                acc_next = acc_ins[WORD_W-1:LANE_W];
                cnt_next = cnt + 2'd1;
            end
            if (out_fire) begin
                state_next = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            cnt    <= '0;
            acc    <= '0;
            word_q <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            acc    <= acc_next;
            word_q <= word_next;
            len_q  <= len_next;
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - directed and randomized checks of byte_packer with PAD 00 and FF
module tb_byte_packer;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    byte_packer_if if0 ();
    byte_packer_if if1 ();

    byte_packer #(.PAD(8'h00)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    byte_packer #(.PAD(8'hFF)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    logic [7:0]  cur[$];
    logic [34:0] exp0[$];
    logic [34:0] exp1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic l, input logic r);
        if0.in_valid = v; if0.in_byte = b; if0.in_last = l; if0.out_ready = r;
        if1.in_valid = v; if1.in_byte = b; if1.in_last = l; if1.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic [7:0] pad);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++)
            w = (w << 8) | 32'(((k < cur.size()) ? cur[k] : pad));
        return w;
    endfunction

    task automatic send_word(input logic [31:0] bytes, input int n, input logic r);
        logic [31:0] t;
        t = bytes;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, t[31:24], (i == n - 1), r);
            t = t << 8;
            tick();
        end
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_out_valid", 32'(if0.out_valid), 32'd0);
        chk("reset_out_word",  if0.out_word, 32'h0);
        chk("reset_out_len",   32'(if0.out_len), 32'd0);
        chk("reset_in_ready",  32'(if0.in_ready), 32'd1);

        send_word(32'h12345678, 4, 1'b1);
        chk("full_valid", 32'(if0.out_valid), 32'd1);
        chk("full_word",  if0.out_word, 32'h12345678);
        chk("full_len",   32'(if0.out_len), 32'd4);
        chk("splitter_first_byte", 32'(if0.out_word[31:24]), 32'h12);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        chk("taken_valid", 32'(if0.out_valid), 32'd0);
        chk("taken_word_kept", if0.out_word, 32'h12345678);

        send_word(32'hABCD0000, 2, 1'b1);
        chk("partial_word_pad00", if0.out_word, 32'hABCD0000);
        chk("partial_len",        32'(if0.out_len), 32'd2);
        chk("partial_word_padff", if1.out_word, 32'hABCDFFFF);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        send_word(32'h01020304, 4, 1'b0);
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        #1;
        chk("stall_in_ready", 32'(if0.in_ready), 32'd0);
        tick();
        chk("stall_valid", 32'(if0.out_valid), 32'd1);
        chk("stall_word",  if0.out_word, 32'h01020304);
        drive(1'b1, 8'h05, 1'b0, 1'b1);
        #1;
        chk("release_in_ready", 32'(if0.in_ready), 32'd1);
        tick();
        chk("release_valid", 32'(if0.out_valid), 32'd0);
        drive(1'b1, 8'h06, 1'b1, 1'b1);
        tick();
        chk("held_byte_accepted", if0.out_word, 32'h05060000);
        chk("held_byte_len", 32'(if0.out_len), 32'd2);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1);
            #1;
            chk("stream_in_ready", 32'(if0.in_ready), 32'd1);
            tick();
            if (i == 4) chk("stream_word1", if0.out_word, 32'h01020304);
            if (i == 8) chk("stream_word2", if0.out_word, 32'h05060708);
        end
        chk("stream_valid2", 32'(if0.out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();

        drive(1'b1, 8'h11, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h22, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h33, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_valid", 32'(if0.out_valid), 32'd0);
        chk("midreset_word",  if0.out_word, 32'h0);
        send_word(32'hA1A2A3A4, 4, 1'b1);
        chk("after_reset_word", if0.out_word, 32'hA1A2A3A4);
        chk("after_reset_len",  32'(if0.out_len), 32'd4);

        send_word(32'h5A000000, 1, 1'b1);
        chk("single_word", if0.out_word, 32'h5A000000);
        chk("single_len",  32'(if0.out_len), 32'd1);
        chk("single_padff", if1.out_word, 32'h5AFFFFFF);

        drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic v, l, r;
            logic [7:0] b;
            logic in_f, out_f;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 2) != 0);
            b = 8'($urandom);
            drive(v, b, l, r);
            #4;
            chk("rnd_in_ready", 32'(if0.in_ready), 32'(exp0.size() == 0 || r));
            chk("rnd_out_valid", 32'(if0.out_valid), 32'(exp0.size() != 0));
            out_f = if0.out_valid && r;
            in_f  = v && if0.in_ready;
            if (out_f && exp0.size() != 0) begin
                chk("rnd_word0", if0.out_word, exp0[0][31:0]);
                chk("rnd_len0",  32'(if0.out_len), 32'(exp0[0][34:32]));
                chk("rnd_word1", if1.out_word, exp1[0][31:0]);
                void'(exp0.pop_front());
                void'(exp1.pop_front());
            end
            if (in_f) begin
                cur.push_back(b);
                if (cur.size() == 4 || l) begin
                    exp0.push_back({3'(cur.size()), pack(8'h00)});
                    exp1.push_back({3'(cur.size()), pack(8'hFF)});
                    cur.delete();
                end
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
